// File: rtl/main_fsm_pkg.sv
//------------------------------------------------------------------------------
// Module   : main_fsm_pkg
// Brief    : Shared state encodings, opcodes and datapath select constants
//            for the multicycle control FSM.
// Config   : MAIN_FSM_ITYPE_EN adds the EXECUTEI state (I-type ALU, op 19).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package main_fsm_pkg;

   // State encodings. EXECUTEI takes the next free code so that every other
   // state keeps the same value whether or not I-type support is built in.
   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_ALUWB    = 4'd7,
      S_BEQ      = 4'd8
`ifdef MAIN_FSM_ITYPE_EN
      ,
      S_EXECUTEI = 4'd9
`endif
   } state_e;

   localparam logic [3:0] ST_FETCH    = S_FETCH;
   localparam logic [3:0] ST_DECODE   = S_DECODE;
   localparam logic [3:0] ST_MEMADR   = S_MEMADR;
   localparam logic [3:0] ST_MEMREAD  = S_MEMREAD;
   localparam logic [3:0] ST_MEMWB    = S_MEMWB;
   localparam logic [3:0] ST_MEMWRITE = S_MEMWRITE;
   localparam logic [3:0] ST_EXECUTER = S_EXECUTER;
   localparam logic [3:0] ST_ALUWB    = S_ALUWB;
   localparam logic [3:0] ST_BEQ      = S_BEQ;
`ifdef MAIN_FSM_ITYPE_EN
   localparam logic [3:0] ST_EXECUTEI = S_EXECUTEI;
`endif

   // Opcodes (instr[6:0])
   localparam logic [6:0] OP_LW  = 7'd3;
   localparam logic [6:0] OP_SW  = 7'd35;
   localparam logic [6:0] OP_R   = 7'd51;
   localparam logic [6:0] OP_BEQ = 7'd99;
   localparam logic [6:0] OP_I   = 7'd19;

   // ALU decoder class
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // Result mux select
   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALURES = 2'b10;

   // ALU operand selects
   localparam logic [1:0] SRCA_PC     = 2'b00;
   localparam logic [1:0] SRCA_OLDPC  = 2'b01;
   localparam logic [1:0] SRCA_RD1    = 2'b10;
   localparam logic [1:0] SRCB_RD2    = 2'b00;
   localparam logic [1:0] SRCB_IMM    = 2'b01;
   localparam logic [1:0] SRCB_FOUR   = 2'b10;

   // Immediate format selects
   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;

endpackage : main_fsm_pkg

`default_nettype wire

// File: rtl/main_fsm_imm_src_deco.sv
//------------------------------------------------------------------------------
// Module   : imm_src_deco
// Brief    : Combinational immediate-format select from the opcode field.
// Config   : MAIN_FSM_ITYPE_EN (op 19 selects the I format, same as default)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module imm_src_deco
   import main_fsm_pkg::*;
(
   input  logic [6:0] op,
   output logic [1:0] imm_src
);

   // Map opcode to immediate format; anything unrecognised falls back to I.
   always_comb begin
      imm_src = IMM_I;
      case (op)
         OP_LW:   imm_src = IMM_I;
         OP_SW:   imm_src = IMM_S;
         OP_BEQ:  imm_src = IMM_B;
`ifdef MAIN_FSM_ITYPE_EN
         OP_I:    imm_src = IMM_I;
`endif
         default: imm_src = IMM_I;
      endcase
   end

endmodule : imm_src_deco

`default_nettype wire

// File: rtl/main_fsm.sv
//------------------------------------------------------------------------------
// Module   : main_fsm
// Brief    : Moore control FSM for a multicycle RISC-V style datapath
//            (lw, sw, R-type, beq; optional I-type ALU).
// Config   : MAIN_FSM_ITYPE_EN enables op 19 via the EXECUTEI state;
//            undefined, op 19 is treated as illegal.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module main_fsm
   import main_fsm_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   output logic       pcUpdate,
   output logic       branch,
   output logic       regWrite,
   output logic       memWrite,
   output logic       irWrite,
   output logic       adrSrc,
   output logic [1:0] aluSrcA,
   output logic [1:0] aluSrcB,
   output logic [1:0] resultSrc,
   output logic [1:0] aluOp,
   output logic [1:0] immSrc,
   output logic       illegalOp
);

   logic [3:0] state_q;
   logic [3:0] state_d;
   logic       op_legal;

   // Opcodes the decoder accepts; everything else returns to FETCH as illegal.
   always_comb begin
      op_legal = 1'b0;
      case (op)
         OP_LW, OP_SW, OP_R, OP_BEQ: op_legal = 1'b1;
`ifdef MAIN_FSM_ITYPE_EN
         OP_I:                       op_legal = 1'b1;
`endif
         default:                    op_legal = 1'b0;
      endcase
   end

   // Next-state logic; op only matters in DECODE and MEMADR.
   always_comb begin
      state_d = ST_FETCH;
      case (state_q)
         ST_FETCH:    state_d = ST_DECODE;
         ST_DECODE: begin
            case (op)
               OP_LW, OP_SW: state_d = ST_MEMADR;
               OP_R:         state_d = ST_EXECUTER;
               OP_BEQ:       state_d = ST_BEQ;
`ifdef MAIN_FSM_ITYPE_EN
               OP_I:         state_d = ST_EXECUTEI;
`endif
               default:      state_d = ST_FETCH;
            endcase
         end
         ST_MEMADR: begin
            case (op)
               OP_LW:   state_d = ST_MEMREAD;
               OP_SW:   state_d = ST_MEMWRITE;
               default: state_d = ST_FETCH;
            endcase
         end
         ST_MEMREAD:  state_d = ST_MEMWB;
         ST_MEMWB:    state_d = ST_FETCH;
         ST_MEMWRITE: state_d = ST_FETCH;
         ST_EXECUTER: state_d = ST_ALUWB;
`ifdef MAIN_FSM_ITYPE_EN
         ST_EXECUTEI: state_d = ST_ALUWB;
`endif
         ST_ALUWB:    state_d = ST_FETCH;
         ST_BEQ:      state_d = ST_FETCH;
         default:     state_d = ST_FETCH;
      endcase
   end

   // State register; reset forces FETCH without waiting for a clock edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // Immediate format follows op directly, independent of state.
   imm_src_deco u_imm_src_deco (
      .op      (op),
      .imm_src (immSrc)
   );

   // State-decoded outputs; write enables are masked while reset is high.
   always_comb begin
      pcUpdate  = 1'b0;
      branch    = 1'b0;
      regWrite  = 1'b0;
      memWrite  = 1'b0;
      irWrite   = 1'b0;
      adrSrc    = 1'b0;
      aluSrcA   = SRCA_PC;
      aluSrcB   = SRCB_RD2;
      resultSrc = RES_ALUOUT;
      aluOp     = ALUOP_ADD;
      illegalOp = 1'b0;
      case (state_q)
         ST_FETCH: begin
            irWrite   = 1'b1;
            pcUpdate  = 1'b1;
            aluSrcB   = SRCB_FOUR;
            resultSrc = RES_ALURES;
         end
         ST_DECODE: begin
            aluSrcA   = SRCA_OLDPC;
            aluSrcB   = SRCB_IMM;
            illegalOp = ~op_legal;
         end
         ST_MEMADR: begin
            aluSrcA   = SRCA_RD1;
            aluSrcB   = SRCB_IMM;
         end
         ST_MEMREAD: begin
            adrSrc    = 1'b1;
         end
         ST_MEMWB: begin
            resultSrc = RES_DATA;
            regWrite  = 1'b1;
         end
         ST_MEMWRITE: begin
            adrSrc    = 1'b1;
            memWrite  = 1'b1;
         end
         ST_EXECUTER: begin
            aluSrcA   = SRCA_RD1;
            aluOp     = ALUOP_FUNCT;
         end
`ifdef MAIN_FSM_ITYPE_EN
         ST_EXECUTEI: begin
            aluSrcA   = SRCA_RD1;
            aluSrcB   = SRCB_IMM;
            aluOp     = ALUOP_FUNCT;
         end
`endif
         ST_ALUWB: begin
            regWrite  = 1'b1;
         end
         ST_BEQ: begin
            aluSrcA   = SRCA_RD1;
            aluOp     = ALUOP_SUB;
            branch    = 1'b1;
         end
         default: begin
            // Unreachable encodings drive nothing and fall back to FETCH.
         end
      endcase
      if (reset) begin
         pcUpdate  = 1'b0;
         irWrite   = 1'b0;
         regWrite  = 1'b0;
         memWrite  = 1'b0;
         branch    = 1'b0;
         illegalOp = 1'b0;
      end
   end

endmodule : main_fsm

`default_nettype wire
